// File: rtl/equiv_check_pkg.sv
// Shared definitions for the equivalence stimulus checker: FSM states,
// verdict reason codes and the stimulus LFSR step.
package equiv_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  localparam logic [1:0] REASON_NONE       = 2'd0;
  localparam logic [1:0] REASON_MISMATCH   = 2'd1;
  localparam logic [1:0] REASON_DEGENERATE = 2'd2;

  // Right-shifting Galois form; taps 32,22,2,1 map to bits 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 32-bit Galois LFSR producing the stimulus stream; load/reset restore SEED
// so every run replays the same vector sequence.
module stim_lfsr #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load,
  output logic [31:0] value
);
  import equiv_check_pkg::*;

  // NOTE: sequential state is updated with <= so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/equiv_stim_checker.sv
// Drives pseudo-random vectors into a module under test and a ground-truth
// model, compares their pipelined outputs and latches a PASS/FAIL verdict.
module equiv_stim_checker #(
  parameter int          IN_W    = 2,
  parameter int          OUT_W   = 1,
  parameter int          LATENCY = 2,
  parameter int          II      = 2,
  parameter int          NUM_VEC = 256,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] test_out,
  input  logic [OUT_W-1:0] gt_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             abort,
  output logic [1:0]       fail_reason,
  output logic [15:0]      fail_index,
  output logic [OUT_W-1:0] fail_test,
  output logic [OUT_W-1:0] fail_gt
);
  import equiv_check_pkg::*;

  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
  localparam logic [3:0]  II_LAST  = 4'(II - 1);

  state_e      state;
  logic [3:0]  ii_cnt;
  logic [15:0] vec_idx;
  logic        any_nonzero;
  logic [31:0] lfsr_value;

  // Tag pipeline: position LATENCY holds the vector whose result is on the
  // DUT outputs at the coming edge.
  logic [LATENCY:0] tag_valid;
  logic [15:0]      tag_idx [0:LATENCY];

  logic        issue;
  logic        checking;
  logic        cmp_valid;
  logic [15:0] cmp_idx;
  logic        cmp_mismatch;
  logic        nonzero_next;

  assign issue = ((state == ST_IDLE) && start) ||
                 ((state == ST_RUN) && (ii_cnt == II_LAST));

  assign checking     = (state == ST_RUN) || (state == ST_DRAIN);
  assign cmp_valid    = checking && tag_valid[LATENCY];
  assign cmp_idx      = tag_idx[LATENCY];
  assign cmp_mismatch = (test_out != gt_out);
  assign nonzero_next = any_nonzero || (|test_out) || (|gt_out);

  stim_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (issue),
    .load    ((state == ST_IDLE) && !start),
    .value   (lfsr_value)
  );

  generate
    if (IN_W < 32) begin : g_lfsr_spare
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^lfsr_value[31:IN_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= issue;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
      end
    end
  end

  // NOTE: only the valid bits need reset; an index is never read while its
  // valid bit is low, so the index array stays a plain unreset shift register.
  always_ff @(posedge clk) begin
    tag_idx[0] <= vec_idx;
    for (int i = 1; i <= LATENCY; i++) begin
      tag_idx[i] <= tag_idx[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stim        <= '0;
      ii_cnt      <= '0;
      vec_idx     <= '0;
      any_nonzero <= 1'b0;
      fail_reason <= REASON_NONE;
      fail_index  <= '0;
      fail_test   <= '0;
      fail_gt     <= '0;
    end else begin
      if (issue) begin
        stim    <= lfsr_value[IN_W-1:0];
        vec_idx <= vec_idx + 16'd1;
        ii_cnt  <= '0;
      end else if (state == ST_RUN) begin
        ii_cnt <= ii_cnt + 4'd1;
      end

      case (state)
        ST_IDLE: if (start) state <= (NUM_VEC == 1) ? ST_DRAIN : ST_RUN;
        ST_RUN:  if (issue && (vec_idx == LAST_IDX)) state <= ST_DRAIN;
        default: ;
      endcase

      // Verdicts come last so they override the RUN->DRAIN step above.
      if (cmp_valid) begin
        any_nonzero <= nonzero_next;
        if (cmp_mismatch) begin
          state       <= ST_FAIL;
          fail_reason <= REASON_MISMATCH;
          fail_index  <= cmp_idx;
          fail_test   <= test_out;
          fail_gt     <= gt_out;
        end else if (cmp_idx == LAST_IDX) begin
          if (nonzero_next) begin
            state       <= ST_PASS;
            fail_reason <= REASON_NONE;
          end else begin
            state       <= ST_FAIL;
            fail_reason <= REASON_DEGENERATE;
            fail_index  <= cmp_idx;
          end
        end
      end
    end
  end

  assign busy  = checking;
  assign done  = (state == ST_PASS) || (state == ST_FAIL);
  assign pass  = (state == ST_PASS);
  assign abort = (state == ST_FAIL);

endmodule

// File: tb/tb_equiv_stim_checker.sv
// Self-checking bench: AND-gate DUT pair behind two register stages, plus a
// single-vector zero-latency instance; expectations come from a vector-level model.
module tb_equiv_stim_checker;

  localparam logic [31:0] SEED_M = 32'h1;
  localparam logic [31:0] SEED_O = 32'h3;
  localparam int          NV     = 64;
  localparam int          IIM    = 2;
  localparam int          LATM   = 2;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic        abort;
    logic [1:0]  reason;
    logic [15:0] index;
    logic        ft;
    logic        fg;
  } verdict_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_m = 1'b0;
  logic start_o = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance and its DUT pair.
  logic [1:0]  stim_m;
  logic        test_m, gt_m;
  logic        busy_m, done_m, pass_m, abort_m;
  logic [1:0]  reason_m;
  logic [15:0] index_m;
  logic        ftest_m, fgt_m;

  bit          zero_mode = 1'b0;
  bit          fault_mode = 1'b0;
  int unsigned cyc = 0;
  logic        t1, t2, g1, g2, flip1;

  equiv_stim_checker #(
    .IN_W(2), .OUT_W(1), .LATENCY(LATM), .II(IIM), .NUM_VEC(NV), .SEED(SEED_M)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .start(start_m), .stim(stim_m),
    .test_out(test_m), .gt_out(gt_m), .busy(busy_m), .done(done_m),
    .pass(pass_m), .abort(abort_m), .fail_reason(reason_m),
    .fail_index(index_m), .fail_test(ftest_m), .fail_gt(fgt_m)
  );

  // Edges since the one that issued vector 0; vector k is held while cyc is
  // in [k*II, k*II+II-1], which is how the faulty DUT finds vector 5.
  always @(posedge clk) begin
    if (start_m && !busy_m && !done_m) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    t1    <= (stim_m[1] & stim_m[0]) & ~zero_mode;
    g1    <= ~(~stim_m[1] | ~stim_m[0]) & ~zero_mode;
    flip1 <= fault_mode && (cyc == 10 || cyc == 11);
    t2    <= t1 ^ flip1;
    g2    <= g1;
  end
  assign test_m = t2;
  assign gt_m   = g2;

  // Single-vector, zero-latency instance with combinational DUTs.
  logic [1:0]  stim_o;
  logic        test_o, gt_o;
  logic        busy_o, done_o, pass_o, abort_o;
  logic [1:0]  reason_o;
  logic [15:0] index_o;
  logic        ftest_o, fgt_o;

  assign test_o = stim_o[1] & stim_o[0];
  assign gt_o   = ~(~stim_o[1] | ~stim_o[0]);

  equiv_stim_checker #(
    .IN_W(2), .OUT_W(1), .LATENCY(0), .II(1), .NUM_VEC(1), .SEED(SEED_O)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_o), .stim(stim_o),
    .test_out(test_o), .gt_out(gt_o), .busy(busy_o), .done(done_o),
    .pass(pass_o), .abort(abort_o), .fail_reason(reason_o),
    .fail_index(index_o), .fail_test(ftest_o), .fail_gt(fgt_o)
  );

  logic [1:0] stim_log [$];
  logic [1:0] first_log [$];
  int         hold_err;
  int         done_cyc;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [1:0] vec_m(input int k);
    logic [31:0] l = SEED_M;
    for (int i = 0; i < k; i++) l = lfsr_step(l);
    return l[1:0];
  endfunction

  // Vector-level reference: evaluate both functions per vector, first
  // mismatch wins, otherwise all-zero outputs are degenerate.
  function automatic void model_main(input bit zero, input bit fault,
                                     output verdict_t v, output int dcyc);
    logic [31:0] l = SEED_M;
    bit nz = 1'b0;
    logic g, t;
    v = '0;
    v.done = 1'b1;
    for (int k = 0; k < NV; k++) begin
      g = zero ? 1'b0 : (l[1] & l[0]);
      t = g ^ (fault && k == 5);
      if (t != g) begin
        v.abort = 1'b1; v.reason = 2'd1; v.index = 16'(k);
        v.ft = t; v.fg = g;
        dcyc = k * IIM + LATM + 1;
        return;
      end
      nz = nz | t | g;
      l = lfsr_step(l);
    end
    dcyc = (NV - 1) * IIM + LATM + 1;
    if (nz) begin
      v.pass = 1'b1;
    end else begin
      v.abort = 1'b1; v.reason = 2'd2; v.index = 16'(NV - 1);
    end
  endfunction

  function automatic verdict_t get_verdict();
    verdict_t v;
    v.busy = busy_m; v.done = done_m; v.pass = pass_m; v.abort = abort_m;
    v.reason = reason_m; v.index = index_m; v.ft = ftest_m; v.fg = fgt_m;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start_m = 1'b0; start_o = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Starts the main instance after a random idle gap and records stim at
  // each issue slot; an optional spurious start and mid-run reset.
  task automatic run_main(input int spur_at, input int abort_at);
    logic [1:0] prev;
    stim_log.delete();
    hold_err = 0;
    done_cyc = -1;
    prev = '0;
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start_m = (c == spur_at);
      if (c % IIM == 0 && stim_log.size() < NV && !done_m) stim_log.push_back(stim_m);
      else if (c > 0 && stim_m !== prev) hold_err++;
      prev = stim_m;
      if (done_m) begin
        done_cyc = c;
        break;
      end
      if (c == abort_at) begin
        start_m = 1'b0;
        do_reset();
        break;
      end
    end
    start_m = 1'b0;
  endtask

  task automatic check_log(input string name);
    for (int k = 0; k < stim_log.size(); k++) begin
      checks++;
      if (stim_log[k] !== vec_m(k)) begin
        errors++;
        $display("FAIL %s stim[%0d]: got %0h expected %0h", name, k, stim_log[k], vec_m(k));
      end
    end
    checks++;
    if (hold_err !== 0) begin
      errors++;
      $display("FAIL %s stim_hold: got %0d changes expected 0", name, hold_err);
    end
  endtask

  task automatic check_run(input string name, input bit zero, input bit fault,
                           input int exp_len);
    verdict_t ev;
    int       ed;
    model_main(zero, fault, ev, ed);
    check_log(name);
    checks++;
    if (stim_log.size() !== exp_len) begin
      errors++;
      $display("FAIL %s vec_count: got %0d expected %0d", name, stim_log.size(), exp_len);
    end
    checks++;
    if (get_verdict() !== ev) begin
      errors++;
      $display("FAIL %s verdict: got %h expected %h", name, get_verdict(), ev);
    end
    checks++;
    if (done_cyc !== ed) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, ed);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (get_verdict() !== verdict_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", get_verdict());
    end
    checks++;
    if (stim_m !== 2'b00) begin
      errors++;
      $display("FAIL reset_stim: got %0h expected 0", stim_m);
    end
    checks++;
    if ({busy_o, done_o, pass_o, abort_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_one_flags: got %b expected 0000", {busy_o, done_o, pass_o, abort_o});
    end
  endtask

  task automatic test_pass();
    do_reset();
    zero_mode = 1'b0; fault_mode = 1'b0;
    run_main(-1, -1);
    check_run("pass", 1'b0, 1'b0, NV);
  endtask

  task automatic test_degenerate();
    do_reset();
    zero_mode = 1'b1; fault_mode = 1'b0;
    run_main(-1, -1);
    check_run("degenerate", 1'b1, 1'b0, NV);
    zero_mode = 1'b0;
  endtask

  task automatic test_mismatch();
    logic [1:0] held;
    verdict_t   v0;
    do_reset();
    fault_mode = 1'b1;
    run_main(-1, -1);
    check_run("mismatch", 1'b0, 1'b1, 7);
    held = stim_m;
    v0 = get_verdict();
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (stim_m !== held) begin
      errors++;
      $display("FAIL mismatch_stim_frozen: got %0h expected %0h", stim_m, held);
    end
    checks++;
    if (get_verdict() !== v0) begin
      errors++;
      $display("FAIL mismatch_verdict_held: got %h expected %h", get_verdict(), v0);
    end
    fault_mode = 1'b0;
  endtask

  task automatic test_reset_restart();
    do_reset();
    run_main(-1, 2 * 10);
    first_log = stim_log;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy_m, done_m, pass_m, abort_m} !== 4'b0000) begin
      errors++;
      $display("FAIL restart_flush: got %b expected 0000", {busy_m, done_m, pass_m, abort_m});
    end
    run_main(-1, -1);
    for (int k = 0; k < first_log.size(); k++) begin
      checks++;
      if (stim_log[k] !== first_log[k]) begin
        errors++;
        $display("FAIL restart_replay[%0d]: got %0h expected %0h", k, stim_log[k], first_log[k]);
      end
    end
    check_run("restart", 1'b0, 1'b0, NV);
  endtask

  task automatic test_back_to_back_start();
    do_reset();
    run_main(int'($urandom_range(1, 120)), -1);
    check_run("start_in_run", 1'b0, 1'b0, NV);
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    start_o = 1'b1;
    @(negedge clk);
    start_o = 1'b0;
    checks++;
    if ({busy_o, pass_o, done_o, stim_o} !== {3'b100, SEED_O[1:0]}) begin
      errors++;
      $display("FAIL single_issue: got %b expected %b", {busy_o, pass_o, done_o, stim_o},
               {3'b100, SEED_O[1:0]});
    end
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, pass_o, abort_o, reason_o} !== 6'b011000) begin
      errors++;
      $display("FAIL single_verdict: got %b expected 011000",
               {busy_o, done_o, pass_o, abort_o, reason_o});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_degenerate();
    test_mismatch();
    test_reset_restart();
    test_back_to_back_start();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
